serial_add_sub: RTL and testbench

- Bit-serial WIDTH-bit adder/subtractor built around one instance of the team's 1-bit full_adder cell.
- Loads two operands on a start pulse and processes one bit per clock, LSB first, with the carry held in a flip-flop.
- Returns a parallel result with carry and signed-overflow flags.
- Sits between a parallel operand source and a consumer that waits for done; it trades WIDTH cycles of latency for a single full-adder cell.

---
 rtl/serial_add_sub_pkg.sv | 16 +
 rtl/full_adder.sv | 13 +
 rtl/serial_add_sub.sv | 121 ++++++++++++
 tb/tb_serial_add_sub.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the bit-counter width helper.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must index bits 0..w-1; never let it collapse to zero bits.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// The team's 1-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, LSB first,
// carry kept in a flop, parallel result with carry and overflow flags.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_sum, fa_cout;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // NOTE: every _d gets its hold value first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_sh_d   = a;
          // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
          b_sh_d   = b ^ {WIDTH{sub}};
          carry_d  = sub;
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        r_sh_d  = {fa_sum, r_sh_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = {fa_sum, r_sh_q[WIDTH-1:1]};
          cout_d   = fa_cout;
          // On the MSB step carry_q is exactly the carry into the MSB.
          ovf_d    = carry_q ^ fa_cout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and back-to-back checks of serial_add_sub at WIDTH=8.
module tb_serial_add_sub;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issues one operation from a negedge and waits for done (bounded).
  // done_k = negedge index at which done was seen (0 if never); inj > 0
  // re-pulses start with a=FF at that RUN cycle.
  task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_sub,
                       input int inj, output int done_k, output int busy_n);
    @(negedge clk);
    start = 1'b1; a = op_a; b = op_b; sub = op_sub;
    done_k = 0;
    busy_n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = (k == inj);
      if (k == inj) a = 8'hFF;
      if (busy) busy_n++;
      if (done) begin
        done_k = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [7:0] r, input logic c, input logic v);
    check({tag, "_result"}, 32'(result), 32'(r));
    check({tag, "_cout"}, 32'(cout), 32'(c));
    check({tag, "_ovf"}, 32'(overflow), 32'(v));
  endtask

  // Counts done pulses over n cycles.
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] r;
    logic       c;
    logic       v;
    string      tag;
  } vec_t;

  initial begin
    int   dk, bn, dn;
    vec_t vecs[5];
    logic [7:0] ra, rb, bb;
    logic       rs;
    logic [8:0] full;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;

    // Reset, with a start pulse that must be ignored.
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check_res("rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);

    // Normal add with latency and single-pulse checks.
    do_op(8'h3C, 8'h1A, 1'b0, 0, dk, bn);
    check("add_done_at", 32'(dk), 9);
    check("add_busy_cycles", 32'(bn), 8);
    check_res("add", 8'h56, 1'b0, 1'b0);
    count_done(3, dn);
    check("add_single_done", 32'(dn), 0);

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_p_01"};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f_p_01"};
    vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "05_m_07"};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "80_m_01"};
    for (int i = 0; i < 4; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, 0, dk, bn);
      check({vecs[i].tag, "_done_at"}, 32'(dk), 9);
      check_res(vecs[i].tag, vecs[i].r, vecs[i].c, vecs[i].v);
    end

    // Start re-pulsed mid-RUN must be ignored.
    do_op(8'h10, 8'h20, 1'b0, 3, dk, bn);
    check("ign_done_at", 32'(dk), 9);
    check_res("ign", 8'h30, 1'b0, 1'b0);
    count_done(12, dn);
    check("ign_single_done", 32'(dn), 0);

    // Reset in RUN cycle 4 aborts without ever producing done.
    @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
    dn = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dn++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_result", 32'(result), 0);
    count_done(15, bn);
    check("abort_no_done", 32'(dn + bn), 0);

    do_op(8'h01, 8'h01, 1'b0, 0, dk, bn);
    check("fresh_done_at", 32'(dk), 9);
    check_res("fresh", 8'h02, 1'b0, 1'b0);

    // Back-to-back random ops against an independent reference model.
    for (int i = 0; i < 5; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      bb = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + {8'b0, rs};
      do_op(ra, rb, rs, 0, dk, bn);
      check("b2b_done_at", 32'(dk), 9);
      check_res("b2b", full[7:0], full[8], (ra[7] == bb[7]) && (full[7] != ra[7]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
